// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared enums and helpers for uart_ctrl
package uart_pkg;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    EVEN = 2'b01,
    ODD  = 2'b10
  } parity_mode_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // The reserved encoding 2'b11 behaves like NONE.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == EVEN) || (mode == ODD);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous FIFO, power-of-2 depth, first-word-fall-through read
module uart_sync_fifo #(
  parameter int G_WIDTH = 10,
  parameter int G_DEPTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_push,
  input  logic [G_WIDTH-1:0] i_data,
  input  logic               i_pop,
  output logic [G_WIDTH-1:0] o_data,
  output logic               o_empty,
  output logic               o_full
);
  localparam int AW = (G_DEPTH > 1) ? $clog2(G_DEPTH) : 1;

  logic [G_WIDTH-1:0] mem_q [G_DEPTH];
  logic [AW-1:0]      wr_ptr_q;
  logic [AW-1:0]      rd_ptr_q;
  logic [AW:0]        count_q;
  logic               do_push;
  logic               do_pop;

  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == (AW+1)'(G_DEPTH));
  assign do_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign do_push = i_push && (!o_full || do_pop);
  assign o_data  = mem_q[rd_ptr_q];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_data;
  end

endmodule

// File: rtl/uart_ctrl.sv
// rtl/uart_ctrl.sv - runtime-configurable full-duplex UART controller
// Define UART_RX_FIFO_EN to buffer received words in a uart_sync_fifo.
module uart_ctrl
  import uart_pkg::*;
#(
  parameter int G_WORD_WIDTH    = 8,
  parameter int G_OVERSAMPLE    = 16,
  parameter int G_DIV_WIDTH     = 16,
  parameter int G_RX_FIFO_DEPTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [G_DIV_WIDTH-1:0]  i_baud_div,
  input  logic [1:0]              i_parity_mode,
  input  logic                    i_stop2,
  input  logic                    i_tx_valid,
  output logic                    o_tx_ready,
  input  logic [G_WORD_WIDTH-1:0] i_tx_data,
  output logic                    o_tx,
  output logic                    o_tx_busy,
  input  logic                    i_rx,
  output logic                    o_rx_valid,
  input  logic                    i_rx_ready,
  output logic [G_WORD_WIDTH-1:0] o_rx_data,
  output logic                    o_rx_frame_err,
  output logic                    o_rx_parity_err,
  output logic                    o_rx_overrun,
  output logic                    o_rx_busy
);
  localparam int OS_W = $clog2(G_OVERSAMPLE);
  localparam int BIT_W = $clog2(G_WORD_WIDTH);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(G_OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_HALF_LAST = OS_W'(G_OVERSAMPLE / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(G_WORD_WIDTH - 1);
  localparam logic [BIT_W-1:0] BIT_PRELAST = BIT_W'(G_WORD_WIDTH - 2);

  if (G_WORD_WIDTH < 5 || G_WORD_WIDTH > 9 || G_OVERSAMPLE < 4 || (G_OVERSAMPLE % 2) != 0 ||
      G_RX_FIFO_DEPTH < 2 || (G_RX_FIFO_DEPTH & (G_RX_FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $fatal(1, "uart_ctrl: illegal parameter combination");
  end

  // Shared oversample tick; >= keeps the counter sane if the divisor shrinks mid-count.
  logic [G_DIV_WIDTH-1:0] div_cnt_q;
  logic [G_DIV_WIDTH-1:0] div_cnt_d;
  logic                   tick;

  assign tick      = (div_cnt_q >= i_baud_div);
  assign div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;

  tx_state_t               tx_state_q, tx_state_d;
  logic [OS_W-1:0]         tx_os_q, tx_os_d;
  logic [BIT_W-1:0]        tx_bit_q, tx_bit_d;
  logic [G_WORD_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic                    tx_par_q, tx_par_d;
  logic                    tx_par_en_q, tx_par_en_d;
  logic                    tx_stop2_q, tx_stop2_d;
  logic                    tx_second_q, tx_second_d;
  logic                    tx_q, tx_d;
  logic                    tx_bit_end;

  assign tx_bit_end = tick && (tx_os_q == OS_LAST);

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_os_d     = tx_os_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    tx_par_d    = tx_par_q;
    tx_par_en_d = tx_par_en_q;
    tx_stop2_d  = tx_stop2_q;
    tx_second_d = tx_second_q;
    tx_d        = tx_q;
    if (tick && tx_state_q != TX_IDLE) begin
      tx_os_d = tx_bit_end ? '0 : tx_os_q + 1'b1;
    end
    case (tx_state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (i_tx_valid) begin
          tx_state_d  = TX_START;
          tx_d        = 1'b0;
          tx_os_d     = '0;
          tx_shift_d  = i_tx_data;
          tx_par_d    = (^i_tx_data) ^ (i_parity_mode == ODD);
          tx_par_en_d = parity_enabled(i_parity_mode);
          tx_stop2_d  = i_stop2;
        end
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_state_d = TX_DATA;
          tx_bit_d   = '0;
          tx_d       = tx_shift_q[0];
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          if (tx_bit_q == BIT_LAST) begin
            tx_second_d = 1'b0;
            if (tx_par_en_q) begin
              tx_state_d = TX_PARITY;
              tx_d       = tx_par_q;
            end else begin
              tx_state_d = TX_STOP;
              tx_d       = 1'b1;
            end
          end else begin
            tx_bit_d   = tx_bit_q + 1'b1;
            tx_shift_d = tx_shift_q >> 1;
            tx_d       = tx_shift_q[1];
          end
        end
      end
      TX_PARITY: begin
        if (tx_bit_end) begin
          tx_state_d = TX_STOP;
          tx_d       = 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          if (tx_stop2_q && !tx_second_q) begin
            tx_second_d = 1'b1;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_d       = 1'b1;
      end
    endcase
  end

  assign o_tx       = tx_q;
  assign o_tx_ready = (tx_state_q == TX_IDLE);
  assign o_tx_busy  = (tx_state_q != TX_IDLE);

  logic                    rx_meta_q, rx_sync_q;
  rx_state_t               rx_state_q, rx_state_d;
  logic [OS_W-1:0]         rx_os_q, rx_os_d;
  logic [OS_W-1:0]         rx_low_q, rx_low_d;
  logic [BIT_W-1:0]        rx_bit_q, rx_bit_d;
  logic [G_WORD_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic                    rx_armed_q, rx_armed_d;
  logic                    rx_par_en_q, rx_par_en_d;
  logic                    rx_odd_q, rx_odd_d;
  logic                    rx_par_err_q, rx_par_err_d;
  logic                    rx_bit_end;
  logic                    rx_push;
  logic                    rx_push_ferr;

  assign rx_bit_end = tick && (rx_os_q == OS_LAST);

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_os_d      = rx_os_q;
    rx_low_d     = rx_low_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_armed_d   = rx_armed_q;
    rx_par_en_d  = rx_par_en_q;
    rx_odd_d     = rx_odd_q;
    rx_par_err_d = rx_par_err_q;
    rx_push      = 1'b0;
    rx_push_ferr = 1'b0;
    if (tick && rx_state_q != RX_IDLE) begin
      rx_os_d = rx_bit_end ? '0 : rx_os_q + 1'b1;
    end
    case (rx_state_q)
      RX_IDLE: begin
        if (tick) begin
          if (!rx_armed_q || rx_sync_q) begin
            rx_armed_d = rx_armed_q | rx_sync_q;
            rx_low_d   = '0;
          end else if (rx_low_q == OS_HALF_LAST) begin
            rx_state_d   = RX_START;
            rx_os_d      = '0;
            rx_low_d     = '0;
            rx_par_en_d  = parity_enabled(i_parity_mode);
            rx_odd_d     = (i_parity_mode == ODD);
            rx_par_err_d = 1'b0;
          end else begin
            rx_low_d = rx_low_q + 1'b1;
          end
        end
      end
      // Confirmation lands mid start bit, so this terminal tick is mid data bit 0.
      RX_START: begin
        if (rx_bit_end) begin
          rx_state_d = RX_DATA;
          rx_bit_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[G_WORD_WIDTH-1:1]};
        end
      end
      RX_DATA: begin
        if (rx_bit_end) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[G_WORD_WIDTH-1:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == BIT_PRELAST) begin
            rx_state_d = rx_par_en_q ? RX_PARITY : RX_STOP;
          end
        end
      end
      RX_PARITY: begin
        if (rx_bit_end) begin
          rx_state_d   = RX_STOP;
          rx_par_err_d = rx_sync_q ^ (^rx_shift_q) ^ rx_odd_q;
        end
      end
      RX_STOP: begin
        if (rx_bit_end) begin
          rx_state_d   = RX_IDLE;
          rx_armed_d   = 1'b0;
          rx_low_d     = '0;
          rx_push      = 1'b1;
          rx_push_ferr = !rx_sync_q;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign o_rx_busy = (rx_state_q != RX_IDLE);

  logic rx_ovr_q, rx_ovr_d;

`ifdef UART_RX_FIFO_EN
  localparam int FW = G_WORD_WIDTH + 2;

  logic          fifo_empty;
  logic          fifo_full;
  logic          fifo_pop;
  logic [FW-1:0] fifo_rdata;

  assign fifo_pop = !fifo_empty && i_rx_ready;
  assign rx_ovr_d = rx_push && fifo_full && !fifo_pop;

  uart_sync_fifo #(
    .G_WIDTH (FW),
    .G_DEPTH (G_RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (rx_push),
    .i_data  ({rx_par_err_q, rx_push_ferr, rx_shift_q}),
    .i_pop   (fifo_pop),
    .o_data  (fifo_rdata),
    .o_empty (fifo_empty),
    .o_full  (fifo_full)
  );

  assign o_rx_valid = !fifo_empty;
  assign {o_rx_parity_err, o_rx_frame_err, o_rx_data} = fifo_empty ? '0 : fifo_rdata;
`else
  logic                    hold_valid_q, hold_valid_d;
  logic [G_WORD_WIDTH-1:0] hold_data_q, hold_data_d;
  logic                    hold_ferr_q, hold_ferr_d;
  logic                    hold_perr_q, hold_perr_d;

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    hold_ferr_d  = hold_ferr_q;
    hold_perr_d  = hold_perr_q;
    rx_ovr_d     = 1'b0;
    if (hold_valid_q && i_rx_ready) hold_valid_d = 1'b0;
    if (rx_push) begin
      if (!hold_valid_q || i_rx_ready) begin
        hold_valid_d = 1'b1;
        hold_data_d  = rx_shift_q;
        hold_ferr_d  = rx_push_ferr;
        hold_perr_d  = rx_par_err_q;
      end else begin
        rx_ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      hold_ferr_q  <= 1'b0;
      hold_perr_q  <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      hold_ferr_q  <= hold_ferr_d;
      hold_perr_q  <= hold_perr_d;
    end
  end

  assign o_rx_valid      = hold_valid_q;
  assign o_rx_data       = hold_data_q;
  assign o_rx_frame_err  = hold_ferr_q;
  assign o_rx_parity_err = hold_perr_q;
`endif

  assign o_rx_overrun = rx_ovr_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      div_cnt_q    <= '0;
      tx_state_q   <= TX_IDLE;
      tx_os_q      <= '0;
      tx_bit_q     <= '0;
      tx_shift_q   <= '0;
      tx_par_q     <= 1'b0;
      tx_par_en_q  <= 1'b0;
      tx_stop2_q   <= 1'b0;
      tx_second_q  <= 1'b0;
      tx_q         <= 1'b1;
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_os_q      <= '0;
      rx_low_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_armed_q   <= 1'b0;
      rx_par_en_q  <= 1'b0;
      rx_odd_q     <= 1'b0;
      rx_par_err_q <= 1'b0;
      rx_ovr_q     <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      tx_state_q   <= tx_state_d;
      tx_os_q      <= tx_os_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      tx_par_q     <= tx_par_d;
      tx_par_en_q  <= tx_par_en_d;
      tx_stop2_q   <= tx_stop2_d;
      tx_second_q  <= tx_second_d;
      tx_q         <= tx_d;
      rx_meta_q    <= i_rx;
      rx_sync_q    <= rx_meta_q;
      rx_state_q   <= rx_state_d;
      rx_os_q      <= rx_os_d;
      rx_low_q     <= rx_low_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_armed_q   <= rx_armed_d;
      rx_par_en_q  <= rx_par_en_d;
      rx_odd_q     <= rx_odd_d;
      rx_par_err_q <= rx_par_err_d;
      rx_ovr_q     <= rx_ovr_d;
    end
  end

endmodule

// File: tb/tb_uart_ctrl.sv
// tb/tb_uart_ctrl.sv - self-checking bench for uart_ctrl
`timescale 1ns/1ps
module tb_uart_ctrl;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic [1:0]  parity_mode;
  logic        stop2;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        tx;
  logic        tx_busy;
  logic        rx_in;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic        rx_ferr;
  logic        rx_perr;
  logic        rx_ovr;
  logic        rx_busy;
  logic        lb_en;
  logic        rx_bb;

  always #5 clk = ~clk;
  assign rx_in = lb_en ? tx : rx_bb;

  uart_ctrl #(
    .G_WORD_WIDTH    (8),
    .G_OVERSAMPLE    (16),
    .G_DIV_WIDTH     (16),
    .G_RX_FIFO_DEPTH (4)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_baud_div      (baud_div),
    .i_parity_mode   (parity_mode),
    .i_stop2         (stop2),
    .i_tx_valid      (tx_valid),
    .o_tx_ready      (tx_ready),
    .i_tx_data       (tx_data),
    .o_tx            (tx),
    .o_tx_busy       (tx_busy),
    .i_rx            (rx_in),
    .o_rx_valid      (rx_valid),
    .i_rx_ready      (rx_ready),
    .o_rx_data       (rx_data),
    .o_rx_frame_err  (rx_ferr),
    .o_rx_parity_err (rx_perr),
    .o_rx_overrun    (rx_ovr),
    .o_rx_busy       (rx_busy)
  );

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  pm;
    logic        stop2;
    logic [15:0] div;
    int          bits;
    logic [7:0]  exp_data;
    logic        exp_perr;
    logic        exp_ferr;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[6];
  int   n_checks = 0;
  int   n_fail = 0;
  int   ovr_cnt = 0;
  int   busy_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (tx_busy) busy_cnt++;
    if (rx_ovr) ovr_cnt++;
    if (rx_valid && rx_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rx_unexpected: got word 0x%0h, expected no word", rx_data);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("rx_data", rx_data, e.data);
        check("rx_parity_err", rx_perr, e.perr);
        check("rx_frame_err", rx_ferr, e.ferr);
      end
    end
  end

  task automatic send_tx(input logic [7:0] d);
    int t = 0;
    while (!tx_ready && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("tx_accept_ready", tx_ready, 1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_tx_idle();
    int t = 0;
    while (tx_busy && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("tx_idle_timeout", tx_busy, 0);
  endtask

  task automatic wait_sb_empty(input int limit);
    int t = 0;
    while (sb_q.size() != 0 && t < limit) begin
      @(negedge clk);
      t++;
    end
    check("sb_drain", sb_q.size(), 0);
  endtask

  // Bit-banged frames use divisor 0, so one bit is 16 clocks.
  task automatic bang_bit(input logic b);
    rx_bb = b;
    repeat (16) @(posedge clk);
  endtask

  task automatic bang_word(input logic [7:0] d);
    bang_bit(1'b0);
    for (int k = 0; k < 8; k++) bang_bit(d[k]);
  endtask

  task automatic count_rx_busy(input int clks, output int hi);
    hi = 0;
    for (int k = 0; k < clks; k++) begin
      @(negedge clk);
      if (rx_busy) hi++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] frame;
    int         hi;
    int         lo_len;
    int         hi_len;

    vecs[0] = '{8'h3C, 2'b01, 1'b1, 16'd3, 12, 8'h3C, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 2'b00, 1'b0, 16'd0, 10, 8'hA5, 1'b0, 1'b0};
    vecs[2] = '{8'h00, 2'b10, 1'b0, 16'd1, 11, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 2'b01, 1'b0, 16'd2, 11, 8'hFF, 1'b0, 1'b0};
    vecs[4] = '{8'h5A, 2'b11, 1'b1, 16'd0, 11, 8'h5A, 1'b0, 1'b0};
    vecs[5] = '{8'h81, 2'b10, 1'b1, 16'd0, 12, 8'h81, 1'b0, 1'b0};

    rst = 1'b1;
    baud_div = '0;
    parity_mode = NONE;
    stop2 = 1'b0;
    tx_valid = 1'b0;
    tx_data = '0;
    rx_ready = 1'b1;
    lb_en = 1'b0;
    rx_bb = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_rx_busy", rx_busy, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_errs", {rx_ferr, rx_perr, rx_ovr}, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    frame = {1'b1, 8'hA5, 1'b0};
    send_tx(8'hA5);
    repeat (8) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("tx8n1_bit%0d", k), tx, frame[k]);
      if (k < 9) repeat (16) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    check("tx8n1_last_stop_busy", {tx_busy, tx_ready}, 2'b10);
    @(negedge clk);
    check("tx8n1_done", {tx_busy, tx_ready}, 2'b01);

    lb_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      int t;
      baud_div    = vecs[i].div;
      parity_mode = vecs[i].pm;
      stop2       = vecs[i].stop2;
      sb_q.push_back('{vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr});
      busy_cnt = 0;
      send_tx(vecs[i].data);
      t = 0;
      while (!rx_busy && t < 5000) begin
        @(negedge clk);
        t++;
      end
      check($sformatf("lb%0d_rx_start", i), rx_busy, 1);
      parity_mode = ~vecs[i].pm;
      stop2       = ~vecs[i].stop2;
      wait_tx_idle();
      hi_len = vecs[i].bits * 16 * (int'(vecs[i].div) + 1);
      lo_len = hi_len - int'(vecs[i].div);
      n_checks++;
      if (busy_cnt < lo_len || busy_cnt > hi_len) begin
        n_fail++;
        $display("FAIL lb%0d_frame_len: got %0d clocks, expected %0d..%0d", i, busy_cnt, lo_len, hi_len);
      end
      wait_sb_empty(5000);
    end

    lb_en = 1'b0;
    rx_bb = 1'b1;
    baud_div = '0;
    stop2 = 1'b0;
    repeat (40) @(posedge clk);

    parity_mode = EVEN;
    sb_q.push_back('{8'h01, 1'b1, 1'b0});
    bang_word(8'h01);
    bang_bit(1'b0);
    bang_bit(1'b1);
    bang_bit(1'b1);
    wait_sb_empty(200);

    parity_mode = NONE;
    sb_q.push_back('{8'h55, 1'b0, 1'b1});
    bang_word(8'h55);
    bang_bit(1'b0);
    count_rx_busy(48, hi);
    check("break_no_restart", hi, 0);
    wait_sb_empty(10);
    rx_bb = 1'b1;
    repeat (64) @(posedge clk);

    rx_bb = 1'b0;
    repeat (5) @(posedge clk);
    rx_bb = 1'b1;
    count_rx_busy(60, hi);
    check("glitch_rx_busy", hi, 0);
    check("glitch_no_word", rx_valid, 0);

    lb_en = 1'b1;
    rx_ready = 1'b0;
    ovr_cnt = 0;
`ifdef UART_RX_FIFO_EN
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) sb_q.push_back('{8'(k * 8'h11), 1'b0, 1'b0});
      send_tx(8'(k * 8'h11));
    end
`else
    sb_q.push_back('{8'h11, 1'b0, 1'b0});
    send_tx(8'h11);
    send_tx(8'h22);
`endif
    wait_tx_idle();
    repeat (32) @(negedge clk);
    check("overrun_pulses", ovr_cnt, 1);
    check("overrun_head_valid", rx_valid, 1);
    check("overrun_head_data", rx_data, 8'h11);
    rx_ready = 1'b1;
    wait_sb_empty(50);
    repeat (8) @(negedge clk);
    check("overrun_drained", rx_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
